// File: rtl/peak_pkg.sv
// -----------------------------------------------------------------------------
// peak_pkg
// Shared definitions for the peak finder and the peak result streamer.
//   - Result entry layout: {index[IDX_W-1:0], value[VAL_W-1:0]}, ENTRY_W bits.
//   - MAX_PEAKS: capacity of the result memory in entries.
//   - PEAK_ADDR_W: address width of the result memory.
//   - state_t: streamer FSM states.
//   - clamp_count(): limits a requested peak count to the memory capacity.
// -----------------------------------------------------------------------------
package peak_pkg;

    localparam int IDX_W       = 13;
    localparam int VAL_W       = 32;
    localparam int ENTRY_W     = IDX_W + VAL_W;
    localparam int MAX_PEAKS   = 35;
    localparam int PEAK_ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        BEAT_IDX,
        BEAT_VAL,
        FINISH
    } state_t;

    // Requested count limited to the number of entries the memory can hold.
    function automatic logic [5:0] clamp_count(input logic [5:0] count,
                                               input logic [5:0] limit);
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/peak_stream_out.sv
// -----------------------------------------------------------------------------
// peak_stream_out
// Reads peak result entries 0..n-1 from the result BRAM and streams each one
// as two 32-bit AXI4-Stream beats: first the zero-extended sample index, then
// the peak value. tlast marks the value beat of the final entry; a one-cycle
// done pulse follows the last handshake.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             level request, only looked at while idle
//   peak_count        number of valid entries, latched on the accepted start
//   busy              high in every state other than IDLE
//   done              one-cycle pulse when the transfer ends
//   bram_clk          BRAM clock, same as clk
//   bram_en/we/addr   BRAM read port control (write side tied off)
//   bram_din          tied to zero
//   bram_dout         entry {index, value}, valid RD_LAT cycles after address
//   m_axis_*          AXI4-Stream master, all outputs registered
// -----------------------------------------------------------------------------
module peak_stream_out #(
    parameter int ADDR_W    = peak_pkg::PEAK_ADDR_W,
    parameter int IDX_W     = peak_pkg::IDX_W,
    parameter int VAL_W     = peak_pkg::VAL_W,
    parameter int RD_LAT    = 2,   // 1..4
    parameter int MAX_PEAKS = peak_pkg::MAX_PEAKS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [5:0]               peak_count,
    output logic                     busy,
    output logic                     done,
    output logic                     bram_clk,
    output logic                     bram_en,
    output logic                     bram_we,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [IDX_W+VAL_W-1:0]   bram_din,
    input  logic [IDX_W+VAL_W-1:0]   bram_dout,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tlast
);

    import peak_pkg::*;

    localparam int EW = IDX_W + VAL_W;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t              state_q;
    logic [5:0]          n_q;          // latched, clamped entry count
    logic [ADDR_W-1:0]   rd_ptr_q;     // entry being read / streamed
    logic [1:0]          wait_q;       // read latency counter
    logic [VAL_W-1:0]    entry_val_q;  // value half of the captured entry
    logic                done_q;
    logic                bram_en_q;
    logic                tvalid_q;
    logic [31:0]         tdata_q;
    logic                tlast_q;

    logic [5:0]          n_d;
    logic                last_entry;

    assign n_d = clamp_count(peak_count, 6'(MAX_PEAKS));

    // rd_ptr never exceeds n-1 (at most 34), so its low 6 bits are exact.
    assign last_entry = (6'(rd_ptr_q) == (n_q - 6'd1));

    // -------------------------------------------------------------------------
    // Transfer FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            rd_ptr_q    <= '0;
            wait_q      <= '0;
            entry_val_q <= '0;
            done_q      <= 1'b0;
            bram_en_q   <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q      <= n_d;
                        rd_ptr_q <= '0;
                        if (n_d != 6'd0) begin
                            bram_en_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end

                RD_ADDR: begin
                    // Address and enable were set on entry; the BRAM
                    // registers them at the end of this cycle.
                    wait_q  <= '0;
                    state_q <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (wait_q == 2'(RD_LAT - 1)) begin
                        // Index beat is loaded straight from the BRAM output
                        // so it is valid in the first BEAT_IDX cycle.
                        entry_val_q <= bram_dout[VAL_W-1:0];
                        tdata_q     <= {{(32-IDX_W){1'b0}}, bram_dout[EW-1:VAL_W]};
                        tlast_q     <= 1'b0;
                        tvalid_q    <= 1'b1;
                        bram_en_q   <= 1'b0;
                        state_q     <= BEAT_IDX;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end

                BEAT_IDX: begin
                    if (m_axis_tready) begin
                        tdata_q <= entry_val_q;
                        tlast_q <= last_entry;
                        state_q <= BEAT_VAL;
                    end
                end

                BEAT_VAL: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tdata_q  <= '0;
                        if (tlast_q) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
                            bram_en_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end
                    end
                end

                FINISH: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign bram_clk      = clk;
    assign bram_en       = bram_en_q;
    assign bram_we       = 1'b0;
    assign bram_addr     = rd_ptr_q;
    assign bram_din      = '0;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_peak_stream_out.sv
// -----------------------------------------------------------------------------
// tb_peak_stream_out
// Self-checking bench for peak_stream_out. A BRAM model with RD_LAT read
// latency feeds the DUT; expected beats are built from the memory contents
// and the clamped count, and cycle counts come from the closed-form timing.
// -----------------------------------------------------------------------------
module tb_peak_stream_out;

    localparam int RD_LAT = 2;
    localparam int MAXP   = 35;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  peak_count;
    logic        busy;
    logic        done;
    logic        bram_clk;
    logic        bram_en;
    logic        bram_we;
    logic [6:0]  bram_addr;
    logic [44:0] bram_din;
    logic [44:0] bram_dout;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;

    always #5 clk = ~clk;

    peak_stream_out #(
        .ADDR_W    (7),
        .IDX_W     (13),
        .VAL_W     (32),
        .RD_LAT    (RD_LAT),
        .MAX_PEAKS (MAXP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .peak_count    (peak_count),
        .busy          (busy),
        .done          (done),
        .bram_clk      (bram_clk),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_dout     (bram_dout),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    // ---------------- BRAM model ----------------
    logic [44:0] mem  [0:127];
    logic [44:0] pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (bram_en) pipe[0] <= mem[bram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_dout = pipe[RD_LAT-1];

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_d[$];
    bit          exp_l[$];
    logic [31:0] got_d[$];
    bit          got_l[$];
    logic [31:0] saved_d[$];
    int          rd_addrs[$];

    bit          mon_en     = 1'b0;
    bit          rand_ready = 1'b0;
    int          mon_c, busy_cycles, en_cycles, stall_cycles;
    int          first_valid_c, first_en_c, last_done_c;
    bit          prev_stall, prev_en;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [6:0]  prev_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 128; i++) mem[i] = {13'($urandom), 32'($urandom)};
    endtask

    task automatic arm_monitor();
        got_d.delete(); got_l.delete(); rd_addrs.delete();
        mon_c = 0; busy_cycles = 0; en_cycles = 0; stall_cycles = 0;
        first_valid_c = -1; first_en_c = -1;
        prev_stall = 1'b0; prev_en = 1'b0;
        mon_en = 1'b1;
    endtask

    // tready driver: changes just after each rising edge
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_c++;
                if (busy) busy_cycles++;
                if (prev_stall) begin
                    chk("hold_valid", m_axis_tvalid, 1'b1);
                    chk("hold_data", m_axis_tdata, prev_data);
                    chk("hold_last", m_axis_tlast, prev_last);
                end
                if (m_axis_tvalid && first_valid_c < 0) first_valid_c = mon_c;
                if (m_axis_tvalid && m_axis_tready) begin
                    got_d.push_back(m_axis_tdata);
                    got_l.push_back(m_axis_tlast);
                end
                if (m_axis_tvalid && !m_axis_tready) stall_cycles++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
                if (bram_en) begin
                    en_cycles++;
                    if (first_en_c < 0) first_en_c = mon_c;
                    if (!prev_en) rd_addrs.push_back(int'(bram_addr));
                    else chk("addr_hold", bram_addr, prev_addr);
                end
                prev_en   = bram_en;
                prev_addr = bram_addr;
            end else begin
                prev_stall = 1'b0;
                prev_en    = 1'b0;
            end
        end
    end

    // One complete transfer plus all model comparisons for it.
    task automatic run_transfer(input int cnt, input bit rnd, input bit disturb, input string tag);
        int n;
        int dc;
        n = (cnt > MAXP) ? MAXP : cnt;
        exp_d.delete(); exp_l.delete();
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(32'(mem[i][44:32])); exp_l.push_back(1'b0);
            exp_d.push_back(mem[i][31:0]);       exp_l.push_back(i == n - 1);
        end
        rand_ready = rnd;
        @(negedge clk);
        start = 1'b1;
        peak_count = 6'(cnt);
        @(posedge clk);
        arm_monitor();
        dc = -1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (done) begin
                dc = k;
                start = 1'b0;
                break;
            end
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                peak_count = 6'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rand_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_done_after"}, done, 1'b0);
        last_done_c = dc;
        chk({tag, "_no_timeout"}, dc > 0, 1'b1);
        chk({tag, "_nbeats"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_last%0d", tag, i), got_l[i], exp_l[i]);
        end
        chk({tag, "_nreads"}, rd_addrs.size(), n);
        for (int i = 0; i < rd_addrs.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), rd_addrs[i], i);
        chk({tag, "_en_cycles"}, en_cycles, n * (RD_LAT + 1));
        chk({tag, "_done_cycle"}, dc, n * (RD_LAT + 3) + 1 + stall_cycles);
        chk({tag, "_busy_cycles"}, busy_cycles, dc);
        if (n > 0) begin
            chk({tag, "_first_en"}, first_en_c, 1);
            chk({tag, "_first_valid"}, first_valid_c, RD_LAT + 2);
        end else begin
            chk({tag, "_no_valid"}, first_valid_c, -1);
        end
        $display("xfer %s count=%0d n=%0d beats=%0d stalls=%0d done_at=%0d",
                 tag, cnt, n, got_d.size(), stall_cycles, dc);
    endtask

    logic [31:0] fixed_beats [6];
    bit          found;
    int          last_sum;

    initial begin
        fixed_beats = '{32'h64, 32'h46A73000, 32'hC8, 32'h3F800000, 32'h1F40, 32'h40000000};
        rst = 1'b1;
        start = 1'b0;
        peak_count = '0;
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
        fill_random();

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_en", bram_en, 1'b0);
        chk("rst_we", bram_we, 1'b0);
        chk("rst_addr", bram_addr, 7'd0);
        chk("rst_din", bram_din, 45'd0);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // ---- three known entries ----
        mem[0] = {13'd100,  32'h46A73000};
        mem[1] = {13'd200,  32'h3F800000};
        mem[2] = {13'd8000, 32'h40000000};
        run_transfer(3, 1'b0, 1'b0, "fixed3");
        for (int i = 0; i < 6 && i < got_d.size(); i++)
            chk($sformatf("fixed3_lit%0d", i), got_d[i], fixed_beats[i]);
        chk("fixed3_done16", last_done_c, 16);

        // ---- zero entries ----
        run_transfer(0, 1'b0, 1'b0, "zero");

        // ---- clamped count ----
        fill_random();
        run_transfer(40, 1'b0, 1'b0, "clamp40");
        chk("clamp40_70beats", got_d.size(), 70);

        // ---- backpressure vs no-stall ----
        fill_random();
        run_transfer(5, 1'b0, 1'b0, "nostall5");
        saved_d = got_d;
        run_transfer(5, 1'b1, 1'b0, "stall5");
        chk("stall5_len_vs_ref", got_d.size(), saved_d.size());
        for (int i = 0; i < saved_d.size() && i < got_d.size(); i++)
            chk($sformatf("stall5_vs_ref%0d", i), got_d[i], saved_d[i]);

        // ---- reset during the value beat of entry 2 ----
        fill_random();
        rand_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        peak_count = 6'd5;
        @(posedge clk);
        arm_monitor();
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (got_d.size() == 5) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstmid_reached", found, 1'b1);
        chk("rstmid_pre_valid", m_axis_tvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_tvalid", m_axis_tvalid, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_en", bram_en, 1'b0);
        chk("rstmid_tlast", m_axis_tlast, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b0;
        chk("rstmid_partial_beats", got_d.size(), 5);
        last_sum = 0;
        foreach (got_l[i]) last_sum += int'(got_l[i]);
        chk("rstmid_no_tlast", last_sum, 0);
        $display("xfer rstmid count=5 beats_before_reset=%0d", got_d.size());
        run_transfer(5, 1'b0, 1'b0, "after_rst");

        // ---- start / peak_count disturbed while busy ----
        fill_random();
        run_transfer(7, 1'b1, 1'b1, "disturb");

        // ---- random counts with random backpressure ----
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_transfer($urandom_range(1, 63), 1'b1, 1'b0, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
